// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and helpers for the AXI4 write-channel arbiter.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_prio_select.sv
// Round-robin priority pick: first set request bit at or after ptr_i, wrapping.
module rr_prio_select
  import axi_wr_arb_pkg::*;
#(
  parameter  int NB_MASTER = 3,
  localparam int IDX_W     = idx_w(NB_MASTER)
) (
  input  logic [NB_MASTER-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 any_req_o
);

  logic hit;

  always_comb begin
    int               s;
    logic [IDX_W-1:0] idx;
    s         = 0;
    idx       = '0;
    hit       = 1'b0;
    gnt_idx_o = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      s = int'(ptr_i) + k;
      if (s >= NB_MASTER) s = s - NB_MASTER;
      idx = IDX_W'(s);
      if (!hit && req_i[idx]) begin
        gnt_idx_o = idx;
        hit       = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write slave port; grant held from AW to B.
// Optional beat-count checking and last-beat forcing: AXI_WR_ARB_BEAT_CHECK_EN.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter  int NB_MASTER      = 3,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int AXI_ID_WIDTH   = 2,
  localparam int IDX_W          = idx_w(NB_MASTER),
  localparam int STRB_W         = AXI_DATA_WIDTH / 8,
  localparam int MID_W          = AXI_ID_WIDTH + IDX_W
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NB_MASTER-1:0]                      aw_valid_i,
  output logic [NB_MASTER-1:0]                      aw_ready_o,
  input  logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0]  aw_addr_i,
  input  logic [NB_MASTER-1:0][7:0]                 aw_len_i,
  input  logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]    aw_id_i,
  input  logic [NB_MASTER-1:0]                      w_valid_i,
  output logic [NB_MASTER-1:0]                      w_ready_o,
  input  logic [NB_MASTER-1:0][AXI_DATA_WIDTH-1:0]  w_data_i,
  input  logic [NB_MASTER-1:0][STRB_W-1:0]          w_strb_i,
  input  logic [NB_MASTER-1:0]                      w_last_i,
  output logic [NB_MASTER-1:0]                      b_valid_o,
  input  logic [NB_MASTER-1:0]                      b_ready_i,
  output logic [1:0]                                b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]                   b_id_o,
  output logic                                      m_aw_valid_o,
  input  logic                                      m_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]                 m_aw_addr_o,
  output logic [7:0]                                m_aw_len_o,
  output logic [MID_W-1:0]                          m_aw_id_o,
  output logic                                      m_w_valid_o,
  input  logic                                      m_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]                 m_w_data_o,
  output logic [STRB_W-1:0]                         m_w_strb_o,
  output logic                                      m_w_last_o,
  input  logic                                      m_b_valid_i,
  output logic                                      m_b_ready_o,
  input  logic [1:0]                                m_b_resp_i,
  input  logic [MID_W-1:0]                          m_b_id_i,
  output logic                                      busy_o,
  output logic [IDX_W-1:0]                          gnt_idx_o
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
  ,
  output logic                                      err_o
`endif
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, sel_idx;
  logic             any_req, w_last_eff;

  rr_prio_select #(.NB_MASTER(NB_MASTER)) u_sel (
    .req_i     (aw_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (sel_idx),
    .any_req_o (any_req)
  );

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       err_q, err_d, aw_hs, w_hs;

  assign aw_hs      = (state_q == AW) & aw_valid_i[gnt_q] & m_aw_ready_i;
  assign w_hs       = (state_q == W)  & w_valid_i[gnt_q]  & m_w_ready_i;
  // Running out of counted beats terminates the burst even without w_last.
  assign w_last_eff = w_last_i[gnt_q] | (beat_cnt_q == 8'd0);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (aw_hs)
      beat_cnt_d = aw_len_i[gnt_q];
    else if (w_hs && beat_cnt_q != 8'd0)
      beat_cnt_d = beat_cnt_q - 8'd1;
    if (w_hs && ((w_last_i[gnt_q] && beat_cnt_q != 8'd0) ||
                 (!w_last_i[gnt_q] && beat_cnt_q == 8'd0)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign w_last_eff = w_last_i[gnt_q];
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    aw_ready_o   = '0;
    w_ready_o    = '0;
    b_valid_o    = '0;
    m_aw_valid_o = 1'b0;
    m_w_valid_o  = 1'b0;
    m_b_ready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = sel_idx;
          state_d = AW;
        end
      end
      AW: begin
        m_aw_valid_o      = aw_valid_i[gnt_q];
        aw_ready_o[gnt_q] = m_aw_ready_i;
        if (aw_valid_i[gnt_q] && m_aw_ready_i) state_d = W;
      end
      W: begin
        m_w_valid_o      = w_valid_i[gnt_q];
        w_ready_o[gnt_q] = m_w_ready_i;
        if (w_valid_i[gnt_q] && m_w_ready_i && w_last_eff) state_d = B;
      end
      B: begin
        b_valid_o[gnt_q] = m_b_valid_i;
        m_b_ready_o      = b_ready_i[gnt_q];
        if (m_b_valid_i && b_ready_i[gnt_q]) begin
          rr_ptr_d = (gnt_q == IDX_W'(NB_MASTER - 1)) ? '0 : gnt_q + IDX_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign m_aw_addr_o = aw_addr_i[gnt_q];
  assign m_aw_len_o  = aw_len_i[gnt_q];
  assign m_aw_id_o   = {gnt_q, aw_id_i[gnt_q]};
  assign m_w_data_o  = w_data_i[gnt_q];
  assign m_w_strb_o  = w_strb_i[gnt_q];
  assign m_w_last_o  = w_last_eff;
  assign b_resp_o    = m_b_resp_i;
  assign b_id_o      = m_b_id_i[AXI_ID_WIDTH-1:0];
  assign busy_o      = (state_q != IDLE);
  assign gnt_idx_o   = gnt_q;

  // Only one burst is ever outstanding, so the returned prefix carries no information.
  logic unused_b_id_prefix;
  assign unused_b_id_prefix = ^m_b_id_i[MID_W-1:AXI_ID_WIDTH];

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: bus-level reference model plus scoreboard.
module tb_axi_wr_arbiter;

  localparam int NM  = 3;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]        aw_valid_i = '0, aw_ready_o;
  logic [NM-1:0][31:0]  aw_addr_i  = '0;
  logic [NM-1:0][7:0]   aw_len_i   = '0;
  logic [NM-1:0][1:0]   aw_id_i    = '0;
  logic [NM-1:0]        w_valid_i  = '0, w_ready_o, w_last_i = '0;
  logic [NM-1:0][31:0]  w_data_i   = '0;
  logic [NM-1:0][3:0]   w_strb_i   = '0;
  logic [NM-1:0]        b_valid_o, b_ready_i = '0;
  logic [1:0]           b_resp_o, b_id_o;
  logic                 m_aw_valid_o, m_aw_ready_i, m_w_valid_o, m_w_ready_i, m_w_last_o;
  logic [31:0]          m_aw_addr_o, m_w_data_o;
  logic [7:0]           m_aw_len_o;
  logic [3:0]           m_aw_id_o, m_b_id_i, m_w_strb_o;
  logic                 m_b_valid_i, m_b_ready_o, busy_o;
  logic [1:0]           m_b_resp_i, gnt_idx_o;
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
  logic                 err_o;
`endif

  axi_wr_arbiter #(.NB_MASTER(NM), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_addr_o(m_aw_addr_o),
    .m_aw_len_o(m_aw_len_o), .m_aw_id_o(m_aw_id_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_data_o(m_w_data_o),
    .m_w_strb_o(m_w_strb_o), .m_w_last_o(m_w_last_o),
    .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o), .m_b_resp_i(m_b_resp_i),
    .m_b_id_i(m_b_id_i), .busy_o(busy_o), .gnt_idx_o(gnt_idx_o)
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    , .err_o(err_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input int i, input int s, input int b);
    logic [31:0] k;
    k = 32'(i * 4096 + s * 16 + b + 1);
    return k * 32'h9E37_79B9;
  endfunction

  function automatic logic [NM-1:0] onehot(input int g);
    return NM'(1) << g;
  endfunction

  // ---------------- reference model: who should win and with what request
  typedef struct {
    int          g;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  id;
    int          seq;
    int          nb;
  } exp_t;

  exp_t exp_q[$];
  int   req_seq [NM];
  int   req_nb  [NM];
  int   m_ptr = 0, m_g = 0;
  bit   m_idle = 1'b1;
  bit   bp_mode = 1'b0;

  initial for (int i = 0; i < NM; i++) begin req_seq[i] = 0; req_nb[i] = 1; end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_idle = 1'b1;
    end else if (m_idle && |aw_valid_i) begin
      m_g = -1;
      for (int k = 0; k < NM; k++)
        if (m_g < 0 && aw_valid_i[(m_ptr + k) % NM]) m_g = (m_ptr + k) % NM;
      exp_q.push_back('{m_g, aw_addr_i[m_g], aw_len_i[m_g], aw_id_i[m_g], req_seq[m_g], req_nb[m_g]});
      m_idle = 1'b0;
    end else if (|(b_valid_o & b_ready_i)) begin
      m_ptr  = (m_g + 1) % NM;
      m_idle = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard
  exp_t cur;
  bit   act = 1'b0;
  int   beat = 0;
  logic [31:0] mon_d;

  always @(negedge clk) begin
    if (rst) begin
      act  = 1'b0;
      beat = 0;
    end else begin
      if (m_aw_valid_o) begin
        chk("aw_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("aw_ready_route", aw_ready_o, m_aw_ready_i ? onehot(exp_q[0].g) : '0);
          if (m_aw_ready_i) begin
            cur = exp_q.pop_front();
            chk("aw_addr", m_aw_addr_o, cur.addr);
            chk("aw_len", m_aw_len_o, cur.len);
            chk("aw_id", m_aw_id_o, {2'(cur.g), cur.id});
            act  = 1'b1;
            beat = 0;
          end
        end
      end
      if (m_w_valid_o && m_w_ready_i) begin
        chk("w_in_burst", act, 1);
        mon_d = beat_data(cur.g, cur.seq, beat);
        chk("w_data", m_w_data_o, mon_d);
        chk("w_strb", m_w_strb_o, mon_d[3:0]);
        chk("w_last", m_w_last_o, beat == cur.nb - 1);
        beat++;
      end
      if (|(b_valid_o & b_ready_i)) begin
        chk("b_route", b_valid_o, onehot(cur.g));
        chk("b_id", b_id_o, cur.id);
        chk("b_resp", b_resp_o, m_b_resp_i);
        chk("b_beats", beat, cur.nb);
        act = 1'b0;
      end
    end
  end

  // ---------------- slave port model
  logic [3:0] sid_q[$];
  bit s_aw_hs, s_wl_hs, s_b_hs, s_pend;
  int s_dly;

  initial begin
    m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0; m_b_valid_i = 1'b0;
    m_b_resp_i = 2'b00; m_b_id_i = 4'h0; s_pend = 1'b0; s_dly = 0;
    forever begin
      @(negedge clk);
      s_aw_hs = m_aw_valid_o & m_aw_ready_i;
      if (s_aw_hs) sid_q.push_back(m_aw_id_o);
      s_wl_hs = m_w_valid_o & m_w_ready_i & m_w_last_o;
      s_b_hs  = m_b_valid_i & m_b_ready_o;
      @(posedge clk); #2;
      if (rst) begin
        sid_q.delete();
        s_pend = 1'b0; m_b_valid_i = 1'b0; m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0;
      end else begin
        m_aw_ready_i = 1'($urandom);
        m_w_ready_i  = bp_mode ? ~m_w_ready_i : ($urandom_range(3) != 0);
        if (s_b_hs) m_b_valid_i = 1'b0;
        if (s_wl_hs) begin s_pend = 1'b1; s_dly = $urandom_range(2); end
        if (s_pend && !m_b_valid_i) begin
          if (s_dly == 0) begin
            m_b_valid_i = 1'b1;
            m_b_id_i    = (sid_q.size() > 0) ? sid_q.pop_front() : 4'h0;
            m_b_resp_i  = 2'($urandom);
            s_pend      = 1'b0;
          end else s_dly--;
        end
      end
    end
  end

  // ---------------- requester driver
  function automatic logic [14:0] idle_outs();
    return {m_aw_valid_o, m_w_valid_o, m_b_ready_o, busy_o, aw_ready_o, w_ready_o, b_valid_o, gnt_idx_o};
  endfunction

  task automatic run_burst(input int i, input logic [31:0] addr, input int len, input int nb,
                           input int abort_after, input int b_delay);
    int n;
    int s;
    logic [31:0] d;
    s = req_seq[i];
    @(posedge clk); #1;
    aw_addr_i[i] = addr; aw_len_i[i] = 8'(len); aw_id_i[i] = 2'($urandom);
    req_nb[i] = nb; aw_valid_i[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(aw_valid_i[i] && aw_ready_o[i]) && n < TMO);
    chk("aw_hs_bound", n < TMO, 1);
    @(posedge clk); #1;
    aw_valid_i[i] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      d = beat_data(i, s, b);
      w_data_i[i] = d; w_strb_i[i] = d[3:0]; w_last_i[i] = (b == nb - 1); w_valid_i[i] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(w_valid_i[i] && w_ready_o[i]) && n < TMO);
      chk("w_hs_bound", n < TMO, 1);
      @(posedge clk); #1;
      w_valid_i[i] = 1'b0; w_last_i[i] = 1'b0;
      if (abort_after == b + 1) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", idle_outs(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_seq[i]++;
        return;
      end
    end
    if (b_delay > 0) begin repeat (b_delay) @(posedge clk); #1; end
    b_ready_i[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(b_valid_o[i] && b_ready_i[i]) && n < TMO);
    chk("b_hs_bound", n < TMO, 1);
    @(posedge clk); #1;
    b_ready_i[i] = 1'b0;
    req_seq[i]++;
  endtask

  function automatic logic [31:0] rnd_addr();
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic fair(input int i);
    for (int k = 0; k < 2; k++) run_burst(i, rnd_addr(), 1, 2, -1, 0);
  endtask

  task automatic rand_traffic(input int i);
    for (int k = 0; k < 6; k++) begin
      int len;
      repeat ($urandom_range(3)) @(posedge clk);
      len = $urandom_range(7);
      run_burst(i, rnd_addr(), len, len + 1, -1, $urandom_range(2));
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycles=60000 expected=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aw_valid_i = '1;
    repeat (3) @(negedge clk);
    chk("reset_outs", idle_outs(), '0);
    @(posedge clk); #1;
    aw_valid_i = '0;
    rst = 1'b0;

    run_burst(1, 32'h0010_0000, 3, 4, -1, 0);

    fork fair(0); fair(1); fair(2); join

    bp_mode = 1'b1;
    fork
      run_burst(0, rnd_addr(), 3, 4, -1, 8);
      begin repeat (3) @(posedge clk); run_burst(2, rnd_addr(), 2, 3, -1, 0); end
    join
    bp_mode = 1'b0;

    fork rand_traffic(0); rand_traffic(1); rand_traffic(2); join

    // Leave the pointer at 2, abort a burst, then 1 must beat 2 after reset.
    run_burst(1, rnd_addr(), 1, 2, -1, 0);
    run_burst(2, rnd_addr(), 3, 4, 2, 0);
    fork
      run_burst(1, rnd_addr(), 0, 1, -1, 0);
      run_burst(2, rnd_addr(), 0, 1, -1, 0);
    join

    run_burst(0, rnd_addr(), 3, 2, -1, 0);
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    @(negedge clk);
    chk("err_set", err_o, 1);
`endif
    run_burst(1, rnd_addr(), 2, 3, -1, 0);
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    @(negedge clk);
    chk("err_sticky", err_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("err_reset", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
